// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 definitions for the front end: opcode field constants, the
// canonical NOP encoding and the fetch FSM state type.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int FETCH_XLEN = 32;

  // Major opcode field values (instr[6:0]) consumed by the control unit.
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,   // presenting a request to instruction memory
    S_WAIT,  // request accepted, waiting for the response
    S_HOLD   // instruction held for decode
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory channel: valid/ready request (address) plus a
// valid-only response (instruction word). At most one request is in flight.
//   master : fetch unit  (drives imem_req_valid, imem_addr)
//   slave  : memory      (drives imem_req_ready, imem_rsp_valid, imem_rsp_data)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter with +4 sequencer, redirect mux and redirect alignment check.
// Ports:
//   clk, rst        clock, synchronous active-high reset (pc <= RESET_PC)
//   redirect_valid  load redirect target (highest priority)
//   redirect_pc     redirect target; low two bits are forced to zero
//   advance         step pc by 4 (wraps modulo 2^XLEN)
//   pc              current fetch address
//   misalign_err    combinational: redirect target is not word aligned
// -----------------------------------------------------------------------------
module fetch_pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err
);

  logic [XLEN-1:0] pc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (advance) begin
      pc_q <= pc_q + XLEN'(4);
    end
  end

  assign pc = pc_q;

  // Flags the same cycle the redirect is sampled; masked during reset so the
  // reset value of the flag is 0.
  assign misalign_err = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage feeding the main decoder. Issues one request at a time to
// instruction memory, holds the returned instruction for decode until it is
// consumed (stall low) or a redirect arrives.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem            instruction-memory channel (master side)
//   stall           decode cannot take the held instruction
//   redirect_valid  taken branch/jump; redirect_pc is the target
//   if_valid        if_* outputs carry a live instruction
//   if_instr, if_opcode, if_pc, if_pc_plus4   held instruction and its PCs
//   misalign_err    redirect target not word aligned (same-cycle pulse)
// Optional (macro FETCH_PERF_CNT_EN):
//   perf_fetch_cnt  instructions consumed by decode
//   perf_kill_cnt   responses discarded because of a redirect
// Only XLEN = 32 is supported.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                if_valid,
  output logic [XLEN-1:0]     if_instr,
  output logic [6:0]          if_opcode,
  output logic [XLEN-1:0]     if_pc,
  output logic [XLEN-1:0]     if_pc_plus4,
  output logic                misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_kill_cnt
`endif
);

  fetch_state_e    state, state_next;
  logic            kill;
  logic [XLEN-1:0] pc;
  logic            rsp_accept;
  logic            rsp_discard;
  logic            hold_release;

  // A response is kept only if no redirect happened since the request was
  // accepted, including one arriving in the same cycle as the response.
  assign rsp_accept   = (state == S_WAIT) && imem.imem_rsp_valid && !kill && !redirect_valid;
  assign rsp_discard  = (state == S_WAIT) && imem.imem_rsp_valid && (kill || redirect_valid);
  assign hold_release = (state == S_HOLD) && !redirect_valid && !stall;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (hold_release),
    .pc             (pc),
    .misalign_err   (misalign_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_REQ:  if (!redirect_valid && imem.imem_req_ready) state_next = S_WAIT;
      S_WAIT: if (imem.imem_rsp_valid) state_next = rsp_accept ? S_HOLD : S_REQ;
      S_HOLD: if (redirect_valid || !stall) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // Outputs. Suppressing req_valid during a redirect means imem_addr (= pc)
  // can only change while no request is being presented.
  always_comb begin
    imem.imem_req_valid = (state == S_REQ) && !redirect_valid;
    imem.imem_addr      = pc;
    if_valid            = (state == S_HOLD);
  end

  // Kill flag and held instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      kill     <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
    end else begin
      if (state == S_WAIT) begin
        if (imem.imem_rsp_valid) kill <= 1'b0;
        else if (redirect_valid) kill <= 1'b1;
      end
      if (rsp_accept) begin
        if_instr <= imem.imem_rsp_data;
        if_pc    <= pc;
      end
    end
  end

  assign if_opcode   = if_instr[6:0];
  assign if_pc_plus4 = if_pc + XLEN'(4);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (hold_release) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (rsp_discard)  perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule
